mem_port_ctrl: RTL and testbench
================================

Name: mem_port_ctrl

Overview:
- Parametrised memory port controller between the riscv core's data/instruction memory interface and a single-port block RAM; supersedes the direct core-to-BRAM wiring.
- Adds a valid/ready request and response handshake, byte/half/word access with per-byte write enables, and load sign/zero extension.
- Tolerates a configurable BRAM read latency and flags misaligned, illegal-size and out-of-range accesses with an error response.

Parameters:
- ADDR_W, 32, width of the core byte address.
- BRAM_ADDR_W, 20, BRAM word-address width; bram_addr = req_addr[BRAM_ADDR_W+1:2].
- MEM_WORDS, 1048576, number of implemented 32-bit words; byte addresses >= 4*MEM_WORDS are out of range.
- READ_LATENCY, 1, cycles from the BRAM sampling bram_en to bram_dout being valid (1 to 4).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_err  out  1  error flag, valid with resp_valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  BRAM_ADDR_W  BRAM word address.
- bram_din  out  32  BRAM write data.
- bram_dout  in  32  BRAM read data.
- stat_rd, stat_wr, stat_err  out  32 each  statistics counters (see Optional Feature).

Behaviour:
- Reset: state IDLE; req_ready=0 during the reset cycle and 1 from the first cycle after rstn rises. resp_valid, resp_err, resp_rdata, bram_en, bram_we, bram_addr, bram_din and the stat counters are all 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid (the accept edge), go to ERR, WRITE or READ as below.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then IDLE. No BRAM strobe.
  - WRITE: bram_en=1 and bram_we=mask for exactly the one cycle after the accept edge. Then resp_valid=1, resp_err=0, resp_rdata=0 for one cycle, then IDLE.
  - READ: bram_en=1, bram_we=0 for exactly one cycle. A latency counter counts READ_LATENCY edges. At the following edge, resp_rdata is captured from bram_dout and resp_valid is held 1 for one cycle, then IDLE.
- Error check (evaluated at the accept edge): size==11, OR half with addr[0]=1, OR word with addr[1:0]!=0, OR addr >= 4*MEM_WORDS.
- Latency from the accept edge to resp_valid high: write = 2 cycles; read = READ_LATENCY+2 cycles; error = 1 cycle.
- req_ready=0 in every state except IDLE. The FSM returns to IDLE in the resp_valid cycle, so a new request can be accepted on the edge ending that cycle (back-to-back operation).
- Store lanes:
  - byte: mask = 0001 << addr[1:0], din = {4{wdata[7:0]}}.
  - half: mask = 0011 << addr[1:0], din = {2{wdata[15:0]}}.
  - word: mask = 1111, din = wdata.
- Load extract: the byte or half is selected by the addr[1:0] registered at the accept edge, then extended to 32 bits per req_unsigned (also registered).
- All request fields are registered at the accept edge. Input changes while req_ready=0 are ignored.
- Reset asserted mid-transaction: abort immediately, no response is issued, and all outputs take their reset values on that edge. A BRAM write already strobed is not undone.

Optional Feature:
- Macro MEM_PORT_STATS_EN.
- Defined:
  - stat_rd increments on each completed non-error load response.
  - stat_wr increments on each completed non-error store response.
  - stat_err increments on each error response.
  - All three saturate at 0xFFFFFFFF and clear on reset.
- Undefined: counters are not implemented and stat_rd, stat_wr, stat_err are constant 0.

Test Plan:
- Word store then load, addr 0x100, wdata 0xDEADBEEF, READ_LATENCY=1 -> store resp 2 cycles after accept with bram_we=1111 and bram_addr=0x40; load resp 3 cycles after accept with rdata 0xDEADBEEF, err=0.
- Byte store 0x80 to addr 0x103, then signed byte load -> bram_we=1000, din=0x80808080; rdata 0xFFFFFF80. The same load with req_unsigned=1 -> rdata 0x00000080.
- Half load addr 0x102 over stored word 0x8001_7FFF, signed -> rdata 0xFFFF8001. Half load at addr 0x101 -> resp_err=1 one cycle after accept, no bram_en pulse.
- READ_LATENCY=3, two back-to-back word loads with req_valid held high -> each resp_valid 5 cycles after its accept; the second request is accepted on the edge ending the first resp_valid cycle.
- Addr 4*MEM_WORDS and req_size=11 -> resp_err=1, rdata=0, no BRAM strobe. With MEM_PORT_STATS_EN defined, stat_err=2 afterwards.
- rstn driven low in the cycle after a read is accepted -> no resp_valid ever appears for it, req_ready=0 during reset, all outputs 0; a normal load succeeds after rstn is released.

Source files
------------

// File: rtl/mem_port_ctrl_if.sv
// Request/response handshake bundle between the core and mem_port_ctrl.
// master = core side (drives requests), slave = controller side.
interface mem_port_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// Memory port controller: core valid/ready requests to a single-port BRAM.
// Ports: clk, rstn (sync, active low); bus (mem_port_ctrl_if.slave: req_*,
// resp_*); bram_en/we/addr/din/dout BRAM side; stat_rd/wr/err counters.
// Optional: define MEM_PORT_STATS_EN to implement the statistics counters.
module mem_port_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int BRAM_ADDR_W  = 20,
    parameter int MEM_WORDS    = 1048576,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    mem_port_ctrl_if.slave         bus,
    output logic                   bram_en,
    output logic [3:0]             bram_we,
    output logic [BRAM_ADDR_W-1:0] bram_addr,
    output logic [31:0]            bram_din,
    input  logic [31:0]            bram_dout,
    output logic [31:0]            stat_rd,
    output logic [31:0]            stat_wr,
    output logic [31:0]            stat_err
);

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        WRITE,
        READ,
        RWAIT
    } state_t;

    localparam logic [63:0] LIMIT = 64'(MEM_WORDS) * 64'd4;
    localparam logic [2:0]  LAT   = 3'(READ_LATENCY);

    state_t state, state_nxt;

    logic                   ready_q;
    logic                   accept;
    logic                   bad;
    logic                   oor;
    logic [3:0]             mask;
    logic [31:0]            din;
    logic [3:0]             mask_q;
    logic [31:0]            din_q;
    logic [BRAM_ADDR_W-1:0] addr_q;
    logic [1:0]             lane_q;
    logic [1:0]             size_q;
    logic                   uns_q;
    logic [2:0]             cnt_q;
    logic                   rd_done;
    logic                   resp_q;
    logic [31:0]            rdata_q;
    logic [31:0]            ext;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;

    // ready_q holds req_ready low through reset and for the reset cycle itself
    assign bus.req_ready  = ready_q & (state == IDLE);
    assign accept         = bus.req_valid & bus.req_ready;
    // read/write responses are registered and land while the FSM is already
    // back in IDLE, which allows back-to-back accepts
    assign bus.resp_valid = resp_q | (state == ERR);
    assign bus.resp_err   = (state == ERR);
    assign bus.resp_rdata = rdata_q;
    assign bram_addr      = addr_q;
    assign bram_din       = din_q;
    assign rd_done        = (state == RWAIT) && (cnt_q == LAT);
    assign oor            = 64'(bus.req_addr) >= LIMIT;

    always_comb begin
        bad  = oor;
        mask = 4'b0000;
        din  = bus.req_wdata;
        unique case (bus.req_size)
            2'b00: begin
                mask = 4'b0001 << bus.req_addr[1:0];
                din  = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                bad  = oor | bus.req_addr[0];
                mask = 4'b0011 << bus.req_addr[1:0];
                din  = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                bad  = oor | (bus.req_addr[1:0] != 2'b00);
                mask = 4'b1111;
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        bram_en   = 1'b0;
        bram_we   = 4'b0000;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bad)             state_nxt = ERR;
                    else if (bus.req_we) state_nxt = WRITE;
                    else                 state_nxt = READ;
                end
            end
            ERR: state_nxt = IDLE;
            WRITE: begin
                bram_en   = 1'b1;
                bram_we   = mask_q;
                state_nxt = IDLE;
            end
            READ: begin
                bram_en   = 1'b1;
                state_nxt = RWAIT;
            end
            RWAIT: begin
                if (rd_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        byte_sel = bram_dout[7:0];
        unique case (lane_q)
            2'd0: byte_sel = bram_dout[7:0];
            2'd1: byte_sel = bram_dout[15:8];
            2'd2: byte_sel = bram_dout[23:16];
            2'd3: byte_sel = bram_dout[31:24];
            default: byte_sel = bram_dout[7:0];
        endcase
        half_sel = lane_q[1] ? bram_dout[31:16] : bram_dout[15:0];
        ext      = bram_dout;
        unique case (size_q)
            2'b00: ext = uns_q ? {24'd0, byte_sel}
                               : {{24{byte_sel[7]}}, byte_sel};
            2'b01: ext = uns_q ? {16'd0, half_sel}
                               : {{16{half_sel[15]}}, half_sel};
            default: ext = bram_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ready_q <= 1'b0;
            mask_q  <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            if (accept) begin
                mask_q <= mask;
                din_q  <= din;
                addr_q <= bus.req_addr[BRAM_ADDR_W+1:2];
                lane_q <= bus.req_addr[1:0];
                size_q <= bus.req_size;
                uns_q  <= bus.req_unsigned;
            end
            // cnt_q counts BRAM edges since the read strobe was sampled
            if (state == READ)       cnt_q <= 3'd1;
            else if (state == RWAIT) cnt_q <= cnt_q + 3'd1;
            if (state == WRITE) resp_q <= 1'b1;
            if (rd_done) begin
                resp_q  <= 1'b1;
                rdata_q <= ext;
            end
        end
    end

`ifdef MEM_PORT_STATS_EN
    logic [31:0] rd_q, wr_q, err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            err_q <= '0;
        end else begin
            if (rd_done && rd_q != '1)               rd_q  <= rd_q + 32'd1;
            if (state == WRITE && wr_q != '1)        wr_q  <= wr_q + 32'd1;
            if (state == ERR && err_q != '1)         err_q <= err_q + 32'd1;
        end
    end

    assign stat_rd  = rd_q;
    assign stat_wr  = wr_q;
    assign stat_err = err_q;
`else
    assign stat_rd  = '0;
    assign stat_wr  = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: one instance at READ_LATENCY=1 and one
// at READ_LATENCY=3, each with a behavioural BRAM; req_valid steered by sel.
`timescale 1ns/1ps
module tb_mem_port_ctrl;

`ifdef MEM_PORT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    int n_run  = 0;
    int n_fail = 0;

    mem_port_ctrl_if #(.ADDR_W(32)) b1 ();
    mem_port_ctrl_if #(.ADDR_W(32)) b3 ();

    assign b1.req_valid    = req_valid & ~sel;
    assign b3.req_valid    = req_valid & sel;
    assign b1.req_we       = req_we;
    assign b3.req_we       = req_we;
    assign b1.req_size     = req_size;
    assign b3.req_size     = req_size;
    assign b1.req_unsigned = req_unsigned;
    assign b3.req_unsigned = req_unsigned;
    assign b1.req_addr     = req_addr;
    assign b3.req_addr     = req_addr;
    assign b1.req_wdata    = req_wdata;
    assign b3.req_wdata    = req_wdata;

    logic        en1, en3;
    logic [3:0]  we1, we3;
    logic [19:0] addr1, addr3;
    logic [31:0] din1, din3, dout1, dout3;
    logic [31:0] srd1, swr1, serr1, srd3, swr3, serr3;

    mem_port_ctrl #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .bus(b1),
        .bram_en(en1), .bram_we(we1), .bram_addr(addr1),
        .bram_din(din1), .bram_dout(dout1),
        .stat_rd(srd1), .stat_wr(swr1), .stat_err(serr1)
    );

    mem_port_ctrl #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .bus(b3),
        .bram_en(en3), .bram_we(we3), .bram_addr(addr3),
        .bram_din(din3), .bram_dout(dout3),
        .stat_rd(srd3), .stat_wr(swr3), .stat_err(serr3)
    );

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] p0, p1;

    always @(posedge clk) begin
        if (en1) begin
            if (we1 == 4'b0000) dout1 <= mem1[addr1[9:0]];
            for (int i = 0; i < 4; i++)
                if (we1[i]) mem1[addr1[9:0]][8*i +: 8] <= din1[8*i +: 8];
        end
    end

    always @(posedge clk) begin
        if (en3) begin
            if (we3 == 4'b0000) p0 <= mem3[addr3[9:0]];
            for (int i = 0; i < 4; i++)
                if (we3[i]) mem3[addr3[9:0]][8*i +: 8] <= din3[8*i +: 8];
        end
        p1    <= p0;
        dout3 <= p1;
    end

    logic        s_ready, s_rvalid, s_err, s_en;
    logic [31:0] s_rdata, s_din, s_addr;
    logic [3:0]  s_we;

    assign s_ready  = sel ? b3.req_ready  : b1.req_ready;
    assign s_rvalid = sel ? b3.resp_valid : b1.resp_valid;
    assign s_err    = sel ? b3.resp_err   : b1.resp_err;
    assign s_rdata  = sel ? b3.resp_rdata : b1.resp_rdata;
    assign s_en     = sel ? en3 : en1;
    assign s_we     = sel ? we3 : we1;
    assign s_addr   = {12'd0, sel ? addr3 : addr1};
    assign s_din    = sel ? din3 : din1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int n;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!s_rvalid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic we,
                      input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int x_lat, input logic x_err,
                      input logic [31:0] x_rdata, input logic x_en,
                      input logic [3:0] x_we, input logic [31:0] x_addr,
                      input logic [31:0] x_din);
        int lat;
        send(we, size, uns, addr, wdata);
        check({tag, ".en"}, 32'(s_en), 32'(x_en));
        check({tag, ".we"}, 32'(s_we), 32'(x_we));
        if (x_en) begin
            check({tag, ".addr"}, s_addr, x_addr);
            check({tag, ".din"}, s_din, x_din);
        end
        wait_resp(lat);
        check({tag, ".lat"}, 32'(lat), 32'(x_lat));
        check({tag, ".err"}, 32'(s_err), 32'(x_err));
        check({tag, ".rdata"}, s_rdata, x_rdata);
    endtask

    int  lat;
    bit  seen;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 32'd0;
            mem3[i] = 32'd0;
        end
        mem3[16] = 32'h1111_2222;
        mem3[17] = 32'h3333_4444;
        sel = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        rstn = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.ready1", 32'(b1.req_ready), 32'd0);
        check("rst.ready3", 32'(b3.req_ready), 32'd0);
        check("rst.rvalid", 32'(b1.resp_valid), 32'd0);
        check("rst.en", 32'(en1), 32'd0);
        check("rst.stat", srd1 | swr1 | serr1, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst.ready_up", 32'(b1.req_ready), 32'd1);

        op("sw",  1, 2'b10, 0, 32'h100, 32'hDEAD_BEEF, 2, 0, 32'h0,
           1, 4'b1111, 32'h40, 32'hDEAD_BEEF);
        op("lw",  0, 2'b10, 0, 32'h100, 32'h0, 3, 0, 32'hDEAD_BEEF,
           1, 4'b0000, 32'h40, 32'h0);
        op("sb",  1, 2'b00, 0, 32'h103, 32'h80, 2, 0, 32'h0,
           1, 4'b1000, 32'h40, 32'h8080_8080);
        op("lb",  0, 2'b00, 0, 32'h103, 32'h0, 3, 0, 32'hFFFF_FF80,
           1, 4'b0000, 32'h40, 32'h0);
        op("lbu", 0, 2'b00, 1, 32'h103, 32'h0, 3, 0, 32'h0000_0080,
           1, 4'b0000, 32'h40, 32'h0);
        op("sw2", 1, 2'b10, 0, 32'h100, 32'h8001_7FFF, 2, 0, 32'h0,
           1, 4'b1111, 32'h40, 32'h8001_7FFF);
        op("lh",  0, 2'b01, 0, 32'h102, 32'h0, 3, 0, 32'hFFFF_8001,
           1, 4'b0000, 32'h40, 32'h0);
        op("lhu", 0, 2'b01, 1, 32'h100, 32'h0, 3, 0, 32'h0000_7FFF,
           1, 4'b0000, 32'h40, 32'h0);
        op("lh_mis", 0, 2'b01, 0, 32'h101, 32'h0, 1, 1, 32'h0,
           0, 4'b0000, 32'h0, 32'h0);
        op("sh",  1, 2'b01, 0, 32'h102, 32'h1234, 2, 0, 32'h0,
           1, 4'b1100, 32'h40, 32'h1234_1234);
        op("lw2", 0, 2'b10, 0, 32'h100, 32'h0, 3, 0, 32'h1234_7FFF,
           1, 4'b0000, 32'h40, 32'h0);
        @(negedge clk);
        check("stat1.rd",  srd1,  STATS ? 32'd6 : 32'd0);
        check("stat1.wr",  swr1,  STATS ? 32'd4 : 32'd0);
        check("stat1.err", serr1, STATS ? 32'd1 : 32'd0);

        // back-to-back loads on the latency-3 instance, req_valid held
        sel = 1'b1;
        @(negedge clk);
        req_we = 1'b0;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = 32'h40;
        req_valid = 1'b1;
        lat = 0;
        while (!s_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1;
        req_addr = 32'h44;
        wait_resp(lat);
        check("b2b.lat1", 32'(lat), 32'd5);
        check("b2b.rdata1", s_rdata, 32'h1111_2222);
        check("b2b.ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b.gap", 32'(s_rvalid), 32'd0);
        check("b2b.busy", 32'(s_ready), 32'd0);
        wait_resp(lat);
        check("b2b.lat2", 32'(lat), 32'd5);
        check("b2b.rdata2", s_rdata, 32'h3333_4444);

        op("oor", 0, 2'b10, 0, 32'h0040_0000, 32'h0, 1, 1, 32'h0,
           0, 4'b0000, 32'h0, 32'h0);
        op("sz11", 1, 2'b11, 0, 32'h0, 32'hFFFF_FFFF, 1, 1, 32'h0,
           0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        check("stat3.err", serr3, STATS ? 32'd2 : 32'd0);
        check("stat3.rd",  srd3,  STATS ? 32'd2 : 32'd0);

        // reset in the READ cycle of an accepted load
        sel = 1'b0;
        send(0, 2'b10, 0, 32'h100, 32'h0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid.ready", 32'(b1.req_ready), 32'd0);
        check("mid.rvalid", 32'(b1.resp_valid), 32'd0);
        check("mid.err", 32'(b1.resp_err), 32'd0);
        check("mid.rdata", b1.resp_rdata, 32'd0);
        check("mid.bram", {en1, we1, 27'd0}, 32'd0);
        check("mid.addr", {12'd0, addr1}, 32'd0);
        check("mid.din", din1, 32'd0);
        check("mid.stat", srd1 | swr1 | serr1, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen |= b1.resp_valid;
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen |= b1.resp_valid;
        end
        check("mid.no_resp", 32'(seen), 32'd0);
        op("lw_rec", 0, 2'b10, 0, 32'h100, 32'h0, 3, 0, 32'h1234_7FFF,
           1, 4'b0000, 32'h40, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
